port_hex_uart_tx: RTL and testbench

PORT_HEX_UART_TX -- requirements
Module: port_hex_uart_tx

---
 rtl/port_hex_uart_pkg.sv | 27 ++
 rtl/port_hex_uart_tx_byte.sv | 78 +++++++
 rtl/port_hex_uart_tx.sv | 85 ++++++++
 tb/tb_port_hex_uart_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/port_hex_uart_pkg.sv
// rtl/port_hex_uart_pkg.sv - shared state encodings, ASCII constants and character helpers
package port_hex_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  typedef enum logic {FRAME_IDLE, FRAME_SEND} frame_state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [2:0] FRAME_CHARS = 3'd6;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character idx of a frame: four hex digits MSB first, then CR, LF.
  function automatic logic [7:0] frame_char(input logic [2:0] idx, input logic [15:0] v);
    case (idx)
      3'd0:    return nibble_to_ascii(v[15:12]);
      3'd1:    return nibble_to_ascii(v[11:8]);
      3'd2:    return nibble_to_ascii(v[7:4]);
      3'd3:    return nibble_to_ascii(v[3:0]);
      3'd4:    return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

endpackage

// File: rtl/port_hex_uart_tx_byte.sv
// rtl/port_hex_uart_tx_byte.sv - 8N1 byte serializer (uart_byte_tx) with valid/ready input
module uart_byte_tx import port_hex_uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t      state;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           bit_end;

  assign bit_end = (cnt == LAST);
  // Ready in the final stop-bit cycle lets the next byte start with no idle gap.
  assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      tx      <= 1'b1;
    end else begin
      cnt <= ((state == IDLE) || bit_end) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: begin
          if (valid) begin
            shreg <= data;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shreg[0];
            bit_idx <= 3'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (valid) begin
              shreg <= data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/port_hex_uart_tx.sv
// rtl/port_hex_uart_tx.sv - sends a changed 16-bit port value as four hex digits plus CR LF
module port_hex_uart_tx import port_hex_uart_pkg::*; #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic [15:0] PortIn,
  input  logic        EnableIn,
  output logic        TxOut,
  output logic        BusyOut,
  output logic [7:0]  FrameCountOut
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  frame_state_t state;
  logic [15:0]  last_value;
  logic [15:0]  snapshot;
  logic [2:0]   char_idx;
  logic         start;
  logic         byte_valid;
  logic         byte_ready;
  logic [7:0]   byte_data;

  assign start = (state == FRAME_IDLE) && EnableIn && (PortIn != last_value);

  // The first digit comes straight from PortIn so the start bit leaves on the detection edge.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = frame_char(3'd0, PortIn);
    if (state == FRAME_IDLE) begin
      byte_valid = start;
    end else if (char_idx != FRAME_CHARS) begin
      byte_valid = 1'b1;
      byte_data  = frame_char(char_idx, snapshot);
    end
  end

  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state         <= FRAME_IDLE;
      last_value    <= 16'h0000;
      snapshot      <= 16'h0000;
      char_idx      <= 3'd0;
      BusyOut       <= 1'b0;
      FrameCountOut <= 8'h00;
    end else begin
      case (state)
        FRAME_IDLE: begin
          if (start && byte_ready) begin
            snapshot   <= PortIn;
            last_value <= PortIn;
            char_idx   <= 3'd1;
            BusyOut    <= 1'b1;
            state      <= FRAME_SEND;
          end
        end
        FRAME_SEND: begin
          if (byte_ready) begin
            if (char_idx == FRAME_CHARS) begin
              BusyOut       <= 1'b0;
              FrameCountOut <= FrameCountOut + 8'd1;
              char_idx      <= 3'd0;
              state         <= FRAME_IDLE;
            end else begin
              char_idx <= char_idx + 3'd1;
            end
          end
        end
        default: state <= FRAME_IDLE;
      endcase
    end
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
    .clk   (clkIn),
    .reset (resetIn),
    .data  (byte_data),
    .valid (byte_valid),
    .ready (byte_ready),
    .tx    (TxOut)
  );

endmodule

// File: tb/tb_port_hex_uart_tx.sv
// tb/tb_port_hex_uart_tx.sv - directed self-checking bench for port_hex_uart_tx
module tb_port_hex_uart_tx;

  logic        clkIn = 1'b0;
  logic        resetIn = 1'b1;
  logic [15:0] PortIn = 16'h0000;
  logic        EnableIn = 1'b1;
  logic        TxOut;
  logic        BusyOut;
  logic [7:0]  FrameCountOut;

  int tests = 0;
  int fails = 0;
  int busy_total = 0;

  always #5 clkIn = ~clkIn;

  always @(negedge clkIn) if (BusyOut === 1'b1) busy_total <= busy_total + 1;

  port_hex_uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .clkIn         (clkIn),
    .resetIn       (resetIn),
    .PortIn        (PortIn),
    .EnableIn      (EnableIn),
    .TxOut         (TxOut),
    .BusyOut       (BusyOut),
    .FrameCountOut (FrameCountOut)
  );

  task automatic apply_reset();
    @(negedge clkIn);
    resetIn  = 1'b1;
    PortIn   = 16'h0000;
    EnableIn = 1'b1;
    repeat (3) @(negedge clkIn);
    resetIn = 1'b0;
    @(negedge clkIn);
  endtask

  // Must be entered at a negedge; returns at the middle of the stop bit.
  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int n;
    ok = 1'b1;
    b  = 8'h00;
    n  = 0;
    while (TxOut !== 1'b0 && n < 3000) begin
      @(negedge clkIn);
      n++;
    end
    if (n >= 3000) begin
      ok = 1'b0;
      return;
    end
    repeat (8) @(negedge clkIn);
    if (TxOut !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clkIn);
      b[i] = TxOut;
    end
    repeat (16) @(negedge clkIn);
    if (TxOut !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_frame(output logic [47:0] f, output logic ok);
    logic [7:0] b;
    logic       bok;
    f  = 48'h0;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_byte(b, bok);
      f = {f[39:0], b};
      if (!bok) ok = 1'b0;
    end
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (BusyOut !== 1'b0 && n < 200) begin
      @(negedge clkIn);
      n++;
    end
  endtask

  task automatic test_reset();
    int errs = 0;
    apply_reset();
    tests++; if (TxOut !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", TxOut); end
    tests++; if (BusyOut !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", BusyOut); end
    tests++; if (FrameCountOut !== 8'h00) begin fails++; $display("FAIL reset_count: got %h expected 00", FrameCountOut); end
    for (int i = 0; i < 2000; i++) begin
      if (TxOut !== 1'b1 || BusyOut !== 1'b0 || FrameCountOut !== 8'h00) errs++;
      @(negedge clkIn);
    end
    tests++; if (errs != 0) begin fails++; $display("FAIL idle_zero_port: %0d bad cycles expected 0", errs); end
  endtask

  task automatic test_frame();
    logic [47:0] f;
    logic ok;
    int b0;
    apply_reset();
    b0 = busy_total;
    PortIn = 16'h1A2F;
    @(negedge clkIn);
    rx_frame(f, ok);
    wait_not_busy();
    tests++; if (!ok) begin fails++; $display("FAIL frame_1a2f_format: got framing error expected clean 8N1"); end
    tests++; if (f !== 48'h31_41_32_46_0D_0A) begin fails++; $display("FAIL frame_1a2f_bytes: got %h expected 314132460d0a", f); end
    tests++; if (busy_total - b0 != 960) begin fails++; $display("FAIL frame_busy_len: got %0d expected 960", busy_total - b0); end
    tests++; if (FrameCountOut !== 8'd1) begin fails++; $display("FAIL frame_count: got %0d expected 1", FrameCountOut); end
  endtask

  task automatic test_coalesce();
    logic [47:0] f1, f2;
    logic [7:0]  b;
    logic ok1, ok2, bok;
    int b0;
    apply_reset();
    PortIn = 16'h0001;
    @(negedge clkIn);
    f1 = 48'h0;
    ok1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_byte(b, bok);
      f1 = {f1[39:0], b};
      if (!bok) ok1 = 1'b0;
      if (i == 0) PortIn = 16'h0002;
      if (i == 1) PortIn = 16'h0003;
    end
    rx_frame(f2, ok2);
    wait_not_busy();
    b0 = busy_total;
    repeat (1200) @(negedge clkIn);
    tests++; if (!ok1 || !ok2) begin fails++; $display("FAIL coalesce_format: got framing error expected clean 8N1"); end
    tests++; if (f1 !== 48'h30_30_30_31_0D_0A) begin fails++; $display("FAIL coalesce_first: got %h expected 303030310d0a", f1); end
    tests++; if (f2 !== 48'h30_30_30_33_0D_0A) begin fails++; $display("FAIL coalesce_second: got %h expected 303030330d0a", f2); end
    tests++; if (busy_total != b0) begin fails++; $display("FAIL coalesce_extra_frame: got %0d busy cycles expected 0", busy_total - b0); end
    tests++; if (FrameCountOut !== 8'd2) begin fails++; $display("FAIL coalesce_count: got %0d expected 2", FrameCountOut); end
  endtask

  task automatic test_reset_mid_frame();
    logic [47:0] f;
    logic [7:0]  b;
    logic ok, bok;
    int n;
    apply_reset();
    PortIn = 16'h1234;
    @(negedge clkIn);
    rx_byte(b, bok);
    n = 0;
    while (TxOut !== 1'b0 && n < 100) begin
      @(negedge clkIn);
      n++;
    end
    tests++; if (n >= 100) begin fails++; $display("FAIL midreset_second_start: got timeout expected start bit"); end
    repeat (69) @(negedge clkIn);
    resetIn = 1'b1;
    PortIn  = 16'h00FF;
    @(negedge clkIn);
    tests++; if (TxOut !== 1'b1 || BusyOut !== 1'b0) begin fails++; $display("FAIL midreset_abort: got tx=%b busy=%b expected tx=1 busy=0", TxOut, BusyOut); end
    resetIn = 1'b0;
    @(negedge clkIn);
    tests++; if (TxOut !== 1'b0 || BusyOut !== 1'b1) begin fails++; $display("FAIL midreset_restart: got tx=%b busy=%b expected tx=0 busy=1", TxOut, BusyOut); end
    rx_frame(f, ok);
    wait_not_busy();
    tests++; if (!ok || f !== 48'h30_30_46_46_0D_0A) begin fails++; $display("FAIL midreset_frame: got %h ok=%b expected 303046460d0a ok=1", f, ok); end
    tests++; if (FrameCountOut !== 8'd1) begin fails++; $display("FAIL midreset_count: got %0d expected 1", FrameCountOut); end
  endtask

  task automatic test_enable();
    logic [47:0] f;
    logic ok;
    int errs = 0;
    apply_reset();
    EnableIn = 1'b0;
    PortIn   = 16'hBEEF;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clkIn);
      if (TxOut !== 1'b1 || BusyOut !== 1'b0) errs++;
    end
    tests++; if (errs != 0) begin fails++; $display("FAIL enable_block: got %0d active cycles expected 0", errs); end
    EnableIn = 1'b1;
    @(negedge clkIn);
    tests++; if (TxOut !== 1'b0) begin fails++; $display("FAIL enable_start_latency: got %b expected 0", TxOut); end
    rx_frame(f, ok);
    wait_not_busy();
    tests++; if (!ok || f !== 48'h42_45_45_46_0D_0A) begin fails++; $display("FAIL enable_frame: got %h ok=%b expected 424545460d0a ok=1", f, ok); end
  endtask

  task automatic test_bit_timing();
    logic [47:0] exp_frame;
    logic [7:0]  c;
    logic        exp_bit;
    logic        busy_last;
    int          ch, pos, errs;
    exp_frame = 48'h35_41_33_43_0D_0A;
    errs = 0;
    busy_last = 1'b0;
    apply_reset();
    PortIn = 16'h5A3C;
    @(negedge clkIn);
    tests++; if (TxOut !== 1'b0) begin fails++; $display("FAIL timing_start_latency: got %b expected 0", TxOut); end
    for (int k = 0; k < 960; k++) begin
      ch  = k / 160;
      pos = (k % 160) / 16;
      c   = exp_frame[47 - 8*ch -: 8];
      if (pos == 0) exp_bit = 1'b0;
      else if (pos == 9) exp_bit = 1'b1;
      else exp_bit = c[pos - 1];
      if (TxOut !== exp_bit) errs++;
      if (k == 959) busy_last = BusyOut;
      @(negedge clkIn);
    end
    tests++; if (errs != 0) begin fails++; $display("FAIL timing_bit_cells: got %0d wrong cycles expected 0", errs); end
    tests++; if (busy_last !== 1'b1 || BusyOut !== 1'b0) begin fails++; $display("FAIL timing_busy_edge: got last=%b after=%b expected 1 then 0", busy_last, BusyOut); end
    tests++; if (TxOut !== 1'b1 || FrameCountOut !== 8'd1) begin fails++; $display("FAIL timing_end_state: got tx=%b count=%0d expected tx=1 count=1", TxOut, FrameCountOut); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_coalesce();
    test_reset_mid_frame();
    test_enable();
    test_bit_timing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
